// File: rtl/fetch_decode_queue_pkg.sv
// Shared constants and types for the fetch/decode instruction queue.
// Holds the virtual address width, default depth and the decode NOP encoding.
package fetch_decode_queue_pkg;

  localparam int          VIRT_ADDR_WIDTH = 32;
  localparam int          FDQ_DEPTH       = 4;
  // Instruction decode substitutes when d_valid is low (RISC-V addi x0,x0,0).
  localparam logic [31:0] FDQ_NOP         = 32'h0000_0013;

  // Occupancy change requested in a cycle, encoded as {push, pop}.
  typedef enum logic [1:0] {
    OP_IDLE = 2'b00,
    OP_POP  = 2'b01,
    OP_PUSH = 2'b10,
    OP_BOTH = 2'b11
  } fdq_op_e;

endpackage

// File: rtl/fdq_storage.sv
// Entry array for the fetch/decode queue: one synchronous write port and one
// asynchronous read port.
module fdq_storage #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 64
) (
  input  logic                     clk,
  input  logic                     i_we,
  input  logic [$clog2(DEPTH)-1:0] i_waddr,
  input  logic [WIDTH-1:0]         i_wdata,
  input  logic [$clog2(DEPTH)-1:0] i_raddr,
  output logic [WIDTH-1:0]         o_rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  // NOTE: the array has no reset; an entry is only read once count covers it,
  // so stale contents are never visible and the flops stay plain DFFs.
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/fetch_decode_queue.sv
// In-order {PC, instruction} queue between fetch and decode with one-cycle flush.
// Define FDQ_BYPASS_EN to forward a fetch straight to decode while the queue is empty.
module fetch_decode_queue
  import fetch_decode_queue_pkg::*;
#(
  parameter int INSTR_WIDTH = 32,
  parameter int PC_WIDTH    = VIRT_ADDR_WIDTH,
  parameter int DEPTH       = FDQ_DEPTH,
  parameter int CNT_W       = $clog2(DEPTH) + 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   flush,
  input  logic                   f_valid,
  output logic                   f_ready,
  input  logic [PC_WIDTH-1:0]    f_pc,
  input  logic [INSTR_WIDTH-1:0] f_instr,
  output logic                   d_valid,
  input  logic                   d_ready,
  output logic [PC_WIDTH-1:0]    d_pc,
  output logic [INSTR_WIDTH-1:0] d_instr,
  output logic [CNT_W-1:0]       count,
  output logic                   full,
  output logic                   empty
);

  localparam int PTR_W   = $clog2(DEPTH);
  localparam int ENTRY_W = PC_WIDTH + INSTR_WIDTH;

  logic [PTR_W-1:0]       r_rd_ptr, r_wr_ptr;
  logic [CNT_W-1:0]       r_count;
  logic [PC_WIDTH-1:0]    r_last_pc;
  logic [INSTR_WIDTH-1:0] r_last_instr;

  logic                   w_empty, w_full;
  logic                   w_bypass, w_bypass_take;
  logic                   w_push, w_pop;
  logic [ENTRY_W-1:0]     w_head;
  fdq_op_e                w_op;

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == CNT_W'(DEPTH));

`ifdef FDQ_BYPASS_EN
  assign w_bypass = w_empty & f_valid & ~flush;
`else
  assign w_bypass = 1'b0;
`endif

  // A bypassed instruction taken by decode in the same cycle is never stored.
  assign w_bypass_take = w_bypass & d_ready;
  assign w_push        = f_valid & ~w_full & ~flush & ~w_bypass_take;
  assign w_pop         = ~w_empty & d_ready & ~flush;
  assign w_op          = fdq_op_e'({w_push, w_pop});

  fdq_storage #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_storage (
    .clk     (clk),
    .i_we    (w_push),
    .i_waddr (r_wr_ptr),
    .i_wdata ({f_pc, f_instr}),
    .i_raddr (r_rd_ptr),
    .o_rdata (w_head)
  );

  always_comb begin
    d_pc    = r_last_pc;
    d_instr = r_last_instr;
    if (w_bypass) begin
      d_pc    = f_pc;
      d_instr = f_instr;
    end else if (!w_empty) begin
      {d_pc, d_instr} = w_head;
    end
  end

  assign d_valid = ~w_empty | w_bypass;
  assign f_ready = ~w_full;
  assign count   = r_count;
  assign full    = w_full;
  assign empty   = w_empty;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rd_ptr     <= '0;
      r_wr_ptr     <= '0;
      r_count      <= '0;
      r_last_pc    <= '0;
      r_last_instr <= '0;
    end else if (flush) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      unique case (w_op)
        OP_PUSH: r_count <= r_count + CNT_W'(1);
        OP_POP:  r_count <= r_count - CNT_W'(1);
        OP_BOTH,
        OP_IDLE: r_count <= r_count;
      endcase
      // Keep the last consumed entry on d_* so decode sees stable values when empty.
      if (w_pop) begin
        {r_last_pc, r_last_instr} <= w_head;
      end else if (w_bypass_take) begin
        r_last_pc    <= f_pc;
        r_last_instr <= f_instr;
      end
    end
  end

endmodule

// File: tb/tb_fetch_decode_queue.sv
// Self-checking bench for fetch_decode_queue: directed vector table, hand-written
// streaming/reset/bypass sequences and a randomized run against a queue model.
module tb_fetch_decode_queue;
  import fetch_decode_queue_pkg::*;

  localparam int DEPTH = 4;
  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam logic [31:0] IMASK = 32'hDEAD_0000;

`ifdef FDQ_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             reset;
  logic             flush, f_valid, d_ready;
  logic             f_ready, d_valid, full, empty;
  logic [31:0]      f_pc, f_instr, d_pc, d_instr;
  logic [CNT_W-1:0] count;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  fetch_decode_queue #(
    .INSTR_WIDTH (32),
    .PC_WIDTH    (32),
    .DEPTH       (DEPTH)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .flush   (flush),
    .f_valid (f_valid),
    .f_ready (f_ready),
    .f_pc    (f_pc),
    .f_instr (f_instr),
    .d_valid (d_valid),
    .d_ready (d_ready),
    .d_pc    (d_pc),
    .d_instr (d_instr),
    .count   (count),
    .full    (full),
    .empty   (empty)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic fl, input logic fv, input logic [31:0] pc,
                       input logic [31:0] ins, input logic dr);
    flush   = fl;
    f_valid = fv;
    f_pc    = pc;
    f_instr = ins;
    d_ready = dr;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
  endtask

  typedef struct {
    logic             fl;
    logic             fv;
    logic [31:0]      pc;
    logic             dr;
    logic [CNT_W-1:0] cnt;
    logic             dv;
    logic [31:0]      dpc;
    logic             full;
    logic             empty;
    logic             frdy;
  } vec_t;

  localparam int NVEC = 18;
  vec_t tbl [NVEC];

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } ent_t;

  ent_t        mq [$];
  logic [31:0] m_last_pc, m_last_instr;
  bit          seen_200 = 1'b0;

  // Records whether the flushed PC ever reaches decode as a valid entry.
  always @(negedge clk) begin
    if (reset && d_valid && d_pc == 32'h200) seen_200 = 1'b1;
  end

  initial begin
    // fl fv pc dr | cnt dv dpc full empty frdy  (outputs after the row's edge)
    tbl[0]  = '{1'b0, 1'b1, 32'h100, 1'b0, 3'd1, 1'b1, 32'h100, 1'b0, 1'b0, 1'b1};
    tbl[1]  = '{1'b0, 1'b1, 32'h104, 1'b0, 3'd2, 1'b1, 32'h100, 1'b0, 1'b0, 1'b1};
    tbl[2]  = '{1'b0, 1'b1, 32'h108, 1'b0, 3'd3, 1'b1, 32'h100, 1'b0, 1'b0, 1'b1};
    tbl[3]  = '{1'b0, 1'b1, 32'h10C, 1'b0, 3'd4, 1'b1, 32'h100, 1'b1, 1'b0, 1'b0};
    tbl[4]  = '{1'b0, 1'b1, 32'h110, 1'b0, 3'd4, 1'b1, 32'h100, 1'b1, 1'b0, 1'b0};
    tbl[5]  = '{1'b0, 1'b0, 32'h000, 1'b1, 3'd3, 1'b1, 32'h104, 1'b0, 1'b0, 1'b1};
    tbl[6]  = '{1'b0, 1'b0, 32'h000, 1'b1, 3'd2, 1'b1, 32'h108, 1'b0, 1'b0, 1'b1};
    tbl[7]  = '{1'b0, 1'b0, 32'h000, 1'b1, 3'd1, 1'b1, 32'h10C, 1'b0, 1'b0, 1'b1};
    tbl[8]  = '{1'b0, 1'b0, 32'h000, 1'b1, 3'd0, 1'b0, 32'h10C, 1'b0, 1'b1, 1'b1};
    tbl[9]  = '{1'b0, 1'b0, 32'h000, 1'b1, 3'd0, 1'b0, 32'h10C, 1'b0, 1'b1, 1'b1};
    tbl[10] = '{1'b0, 1'b1, 32'h180, 1'b0, 3'd1, 1'b1, 32'h180, 1'b0, 1'b0, 1'b1};
    tbl[11] = '{1'b0, 1'b1, 32'h184, 1'b0, 3'd2, 1'b1, 32'h180, 1'b0, 1'b0, 1'b1};
    tbl[12] = '{1'b0, 1'b1, 32'h188, 1'b0, 3'd3, 1'b1, 32'h180, 1'b0, 1'b0, 1'b1};
    tbl[13] = '{1'b1, 1'b1, 32'h200, 1'b1, 3'd0, 1'b0, 32'h10C, 1'b0, 1'b1, 1'b1};
    tbl[14] = '{1'b1, 1'b1, 32'h204, 1'b0, 3'd0, 1'b0, 32'h10C, 1'b0, 1'b1, 1'b1};
    tbl[15] = '{1'b0, 1'b1, 32'h300, 1'b0, 3'd1, 1'b1, 32'h300, 1'b0, 1'b0, 1'b1};
    tbl[16] = '{1'b0, 1'b1, 32'h304, 1'b1, 3'd1, 1'b1, 32'h304, 1'b0, 1'b0, 1'b1};
    tbl[17] = '{1'b0, 1'b1, 32'h308, 1'b0, 3'd2, 1'b1, 32'h304, 1'b0, 1'b0, 1'b1};

    // Reset state, checked both during and after reset.
    reset = 1'b0;
    idle();
    #3;
    check("rst_count_in", 64'(count), 64'd0);
    check("rst_dvalid_in", 64'(d_valid), 64'd0);
    #9 reset = 1'b1;
    #1;
    check("rst_count", 64'(count), 64'd0);
    check("rst_empty", 64'(empty), 64'd1);
    check("rst_full", 64'(full), 64'd0);
    check("rst_dvalid", 64'(d_valid), 64'd0);
    check("rst_fready", 64'(f_ready), 64'd1);
    check("rst_dpc", 64'(d_pc), 64'd0);
    check("rst_dinstr", 64'(d_instr), 64'd0);

    // Directed vectors: fill, full back-pressure, drain, empty pop, flush, refill.
    for (int i = 0; i < NVEC; i++) begin
      drive(tbl[i].fl, tbl[i].fv, tbl[i].pc, tbl[i].pc ^ IMASK, tbl[i].dr);
      @(posedge clk);
      #1 idle();
      #1;
      check($sformatf("vec%0d_count", i), 64'(count), 64'(tbl[i].cnt));
      check($sformatf("vec%0d_dvalid", i), 64'(d_valid), 64'(tbl[i].dv));
      check($sformatf("vec%0d_dpc", i), 64'(d_pc), 64'(tbl[i].dpc));
      check($sformatf("vec%0d_dinstr", i), 64'(d_instr), 64'(tbl[i].dpc ^ IMASK));
      check($sformatf("vec%0d_full", i), 64'(full), 64'(tbl[i].full));
      check($sformatf("vec%0d_empty", i), 64'(empty), 64'(tbl[i].empty));
      check($sformatf("vec%0d_fready", i), 64'(f_ready), 64'(tbl[i].frdy));
    end
    check("flushed_pc_never_seen", 64'(seen_200), 64'd0);

    // Streaming from count=2 (queue holds 0x304, 0x308): push and pop every cycle.
    for (int i = 0; i < 20; i++) begin
      logic [31:0] exp_head;
      drive(1'b0, 1'b1, 32'h400 + 32'(4 * i), (32'h400 + 32'(4 * i)) ^ IMASK, 1'b1);
      @(posedge clk);
      #1 idle();
      #1;
      exp_head = (i == 0) ? 32'h308 : 32'h400 + 32'(4 * (i - 1));
      check($sformatf("stream%0d_count", i), 64'(count), 64'd2);
      check($sformatf("stream%0d_dpc", i), 64'(d_pc), 64'(exp_head));
    end

    // Asynchronous reset mid-cycle with two entries held.
    #1 reset = 1'b0;
    #1;
    check("areset_count", 64'(count), 64'd0);
    check("areset_empty", 64'(empty), 64'd1);
    check("areset_dvalid", 64'(d_valid), 64'd0);
    check("areset_fready", 64'(f_ready), 64'd1);
    check("areset_dpc", 64'(d_pc), 64'd0);
    #3 reset = 1'b1;
    @(posedge clk);
    #1;
    check("areset_hold_count", 64'(count), 64'd0);
    #1;

    // Randomized traffic against a queue-based reference model.
    mq.delete();
    m_last_pc    = '0;
    m_last_instr = '0;
    for (int i = 0; i < 400; i++) begin
      logic        r_fl, r_fv, r_dr, m_empty, m_byp, m_take, m_pop, m_push;
      logic [31:0] r_pc, r_ins, e_pc, e_ins;
      r_fl  = ($urandom_range(0, 15) == 0);
      r_fv  = ($urandom_range(0, 3) != 0);
      r_dr  = ((i / 50) % 2 == 0) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      r_pc  = $urandom;
      r_ins = $urandom;
      drive(r_fl, r_fv, r_pc, r_ins, r_dr);
      #2;
      m_empty = (mq.size() == 0);
      m_byp   = BYP && m_empty && r_fv && !r_fl;
      if (m_byp) begin
        e_pc  = r_pc;
        e_ins = r_ins;
      end else if (!m_empty) begin
        e_pc  = mq[0].pc;
        e_ins = mq[0].instr;
      end else begin
        e_pc  = m_last_pc;
        e_ins = m_last_instr;
      end
      check("rand_count", 64'(count), 64'(mq.size()));
      check("rand_dvalid", 64'(d_valid), 64'(!m_empty || m_byp));
      check("rand_fready", 64'(f_ready), 64'(mq.size() != DEPTH));
      check("rand_full", 64'(full), 64'(mq.size() == DEPTH));
      if (!m_empty || m_byp) begin
        check("rand_dpc", 64'(d_pc), 64'(e_pc));
        check("rand_dinstr", 64'(d_instr), 64'(e_ins));
      end
      @(posedge clk);
      if (r_fl) begin
        mq.delete();
      end else begin
        m_take = m_byp && r_dr;
        m_pop  = !m_empty && r_dr;
        m_push = r_fv && (mq.size() != DEPTH) && !m_take;
        if (m_pop) begin
          ent_t e;
          e = mq.pop_front();
          m_last_pc    = e.pc;
          m_last_instr = e.instr;
        end
        if (m_take) begin
          m_last_pc    = r_pc;
          m_last_instr = r_ins;
        end
        if (m_push) mq.push_back('{r_pc, r_ins});
      end
      #2;
    end

`ifdef FDQ_BYPASS_EN
    // Bypass: empty queue, fetch and decode both ready -> same-cycle delivery.
    drive(1'b1, 1'b0, 32'h0, 32'h0, 1'b0);
    @(posedge clk);
    #2;
    drive(1'b0, 1'b1, 32'h300, 32'h300 ^ IMASK, 1'b1);
    #2;
    check("bypass_dvalid", 64'(d_valid), 64'd1);
    check("bypass_dpc", 64'(d_pc), 64'h300);
    check("bypass_count_pre", 64'(count), 64'd0);
    @(posedge clk);
    #1 idle();
    #1;
    check("bypass_count_post", 64'(count), 64'd0);
    check("bypass_dvalid_post", 64'(d_valid), 64'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
